rng_bias_monitor: RTL and testbench
===================================

RNG_BIAS_MONITOR -- requirements
Module: rng_bias_monitor

Interface
REQ-001 SHALL have parameter TOL, default 8, max allowed |ones - N/2| before a window is judged biased.
REQ-002 SHALL have parameter CNT_W, default 10, width of the ones/sample counters; holds values up to 512.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rng_bit  input  1  raw RNG sample.
REQ-006 SHALL have port rng_valid  input  1  rng_bit qualifier; a sample is consumed only when high.
REQ-007 SHALL have port start  input  1  one-cycle request to run a four-window evaluation.
REQ-008 SHALL have port win_sel  input  2  window length N: 0=64, 1=128, 2=256, 3=512.
REQ-009 SHALL have ports bit_a, bit_b, bit_c, bit_d  output  1 each  bias verdicts for windows 0..3 (1 = biased); these feed the calibration FSM decision inputs.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse; verdicts are valid from this cycle on.

Function
REQ-012 SHALL implement FSM states IDLE, COLLECT, EVAL, DONE.
REQ-013 IDLE: start=1 SHALL latch win_sel, clear the sample and ones counters, set the window index to 0 and go to COLLECT.
REQ-014 start while not in IDLE SHALL be ignored; win_sel changes after acceptance SHALL have no effect.
REQ-015 COLLECT: each cycle with rng_valid=1 SHALL increment the sample count and add rng_bit to the ones count; rng_valid=0 cycles SHALL leave both counts unchanged.
REQ-016 COLLECT SHALL go to EVAL in the cycle after the Nth valid sample is consumed.
REQ-017 EVAL SHALL last one cycle: verdict = 1 iff ones > N/2+TOL or ones < N/2-TOL; ones exactly N/2±TOL SHALL give 0.
REQ-018 EVAL SHALL write the verdict to bit_a/b/c/d for window index 0/1/2/3, clear both counters, then go to COLLECT if index<3 (index increments) or to DONE if index=3.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 bit_a..bit_d SHALL hold their values in IDLE until overwritten by the next run; each bit SHALL be written only by its own window's EVAL.
REQ-021 Total latency from accepted start to done SHALL be 4*(N valid samples) + 4 EVAL cycles + 2 cycles (the accept cycle and DONE entry), with rng_valid held high.
REQ-022 Counters SHALL be wide enough never to wrap at N=512; comparisons SHALL be unsigned with no truncation.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counters 0, window index 0, bit_a..bit_d 0, busy 0, done 0, independent of clk.
REQ-024 rst asserted mid-run SHALL abort the run with no done pulse; the first start after rst deassertion SHALL start a fresh run.

Configuration
REQ-025 Macro RNG_BIAS_DBG_CNT_EN, when defined, SHALL add output ones_cnt (CNT_W bits) that holds the ones count of the most recently evaluated window, updated in EVAL and reset to 0.
REQ-026 Without RNG_BIAS_DBG_CNT_EN, the ones_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 win_sel=0, rng_valid=1, rng_bit alternating 0/1 for all 4 windows -> ones=32 each, bit_a..d=0000, done after 4*64+6 cycles.
REQ-028 win_sel=0, window 1 all ones, others alternating -> bit_b=1, bit_a=bit_c=bit_d=0.
REQ-029 win_sel=1, window 0 with exactly 72 ones -> bit_a=0; 73 ones -> bit_a=1; 55 ones -> bit_a=1; 56 ones -> bit_a=0.
REQ-030 rng_valid toggling 50% duty, win_sel=0 -> exactly 64 valid samples counted per window; start pulsed during busy -> ignored, single done.
REQ-031 rst pulsed mid-COLLECT of window 2 -> outputs 0 immediately, no done; subsequent start completes a normal run.
REQ-032 With RNG_BIAS_DBG_CNT_EN, win_sel=3, all-zero stream -> ones_cnt=0 and bit_a..d=1111; with all-one stream -> ones_cnt=512.

Source files
------------

// File: rtl/rng_bias_monitor.sv
// rng_bias_monitor: runs four back-to-back monobit bias tests on a qualified RNG bit stream.
// Defining RNG_BIAS_DBG_CNT_EN adds the ones_cnt debug output.
module rng_bias_monitor #(
  parameter int TOL   = 8,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rng_bit,
  input  logic       rng_valid,
  input  logic       start,
  input  logic [1:0] win_sel,
  output logic       bit_a,
  output logic       bit_b,
  output logic       bit_c,
  output logic       bit_d,
  output logic       busy,
  output logic       done
`ifdef RNG_BIAS_DBG_CNT_EN
  ,
  output logic [CNT_W-1:0] ones_cnt
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EVAL    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CNT_W:0] TOL_EXT = (CNT_W+1)'(TOL);

  logic [1:0]       state;
  logic [1:0]       win_sel_q;
  logic [1:0]       win_idx;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W:0]   half_ext;
  logic [CNT_W:0]   ones_ext;
  logic             biased;
  logic             last_sample;

  assign win_len  = CNT_W'(64) << win_sel_q;
  assign half_ext = {1'b0, win_len} >> 1;
  assign ones_ext = {1'b0, ones_q};

  // One extra bit keeps N/2+TOL from wrapping; the low bound is rearranged to avoid subtraction.
  assign biased      = (ones_ext > (half_ext + TOL_EXT)) || ((ones_ext + TOL_EXT) < half_ext);
  assign last_sample = rng_valid && (sample_cnt == (win_len - CNT_W'(1)));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      win_sel_q  <= 2'd0;
      win_idx    <= 2'd0;
      sample_cnt <= '0;
      ones_q     <= '0;
      bit_a      <= 1'b0;
      bit_b      <= 1'b0;
      bit_c      <= 1'b0;
      bit_d      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win_sel_q  <= win_sel;
            sample_cnt <= '0;
            ones_q     <= '0;
            win_idx    <= 2'd0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (rng_valid) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            ones_q     <= ones_q + CNT_W'(rng_bit);
            if (last_sample) begin
              state <= EVAL;
            end
          end
        end
        EVAL: begin
          case (win_idx)
            2'd0: bit_a <= biased;
            2'd1: bit_b <= biased;
            2'd2: bit_c <= biased;
            2'd3: bit_d <= biased;
          endcase
          sample_cnt <= '0;
          ones_q     <= '0;
          if (win_idx == 2'd3) begin
            state <= DONE;
          end else begin
            win_idx <= win_idx + 2'd1;
            state   <= COLLECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RNG_BIAS_DBG_CNT_EN
  // Snapshot of the window just judged, kept until the next EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (state == EVAL) begin
      ones_cnt <= ones_q;
    end
  end
`endif

endmodule

// File: tb/tb_rng_bias_monitor.sv
// tb_rng_bias_monitor: directed self-checking bench for rng_bias_monitor.
// Build with RNG_BIAS_DBG_CNT_EN defined to also exercise the ones_cnt debug output.
module tb_rng_bias_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       rng_bit;
  logic       rng_valid;
  logic       start;
  logic [1:0] win_sel;
  logic       bit_a, bit_b, bit_c, bit_d;
  logic       busy, done;
`ifdef RNG_BIAS_DBG_CNT_EN
  logic [9:0] ones_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int done_seen;

  always #5 clk = ~clk;

  rng_bias_monitor #(.TOL(8), .CNT_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .rng_bit   (rng_bit),
    .rng_valid (rng_valid),
    .start     (start),
    .win_sel   (win_sel),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .bit_c     (bit_c),
    .bit_d     (bit_d),
    .busy      (busy),
    .done      (done)
`ifdef RNG_BIAS_DBG_CNT_EN
    ,
    .ones_cnt  (ones_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Feeds n valid samples (alternating, or n_ones leading ones then zeros). With gap set, each
  // sample is followed by an invalid cycle carrying rng_bit=1; the last of those doubles as EVAL.
  // Without gap, trail adds one invalid cycle to cover EVAL. start_at pulses start and moves win_sel.
  task automatic applyStimulus(input int n, input int n_ones, input bit alt, input bit gap,
                               input bit trail, input int start_at);
    for (int i = 0; i < n; i++) begin
      rng_valid = 1'b1;
      rng_bit   = alt ? i[0] : (i < n_ones);
      if (i == start_at) begin
        start   = 1'b1;
        win_sel = 2'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (gap) begin
        rng_valid = 1'b0;
        rng_bit   = 1'b1;
        @(posedge clk); #1;
      end
    end
    if (trail && !gap) begin
      rng_valid = 1'b0;
      rng_bit   = 1'b1;
      @(posedge clk); #1;
    end
    rng_valid = 1'b0;
  endtask

  task automatic doStart(input logic [1:0] sel, input string tag);
    win_sel   = sel;
    rng_valid = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Called right after the last window's EVAL edge: done must be up now and gone one cycle later.
  task automatic finishRun(input string tag, input logic [3:0] exp_bits);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_bits"}, 32'({bit_a, bit_b, bit_c, bit_d}), 32'(exp_bits));
    @(posedge clk); #1;
    checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    rng_bit   = 1'b0;
    rng_valid = 1'b0;
    start     = 1'b0;
    win_sel   = 2'd0;
    #1;
    checkOutput("reset_bits", 32'({bit_a, bit_b, bit_c, bit_d}), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Alternating stream, valid held high: start cycle + 4*64 samples + 4 EVAL + DONE = 4*64+6 cycles
    doStart(2'd0, "t1");
    cyc = 1;
    while (!done && cyc < 2000) begin
      rng_valid = 1'b1;
      rng_bit   = ~rng_bit;
      @(posedge clk); #1;
      cyc++;
    end
    rng_valid = 1'b0;
    checkOutput("t1_latency", 32'(cyc + 1), 32'(4 * 64 + 6));
    finishRun("t1", 4'b0000);

    // Window 1 all ones, others alternating
    doStart(2'd0, "t2");
    applyStimulus(64, 0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(64, 64, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(64, 0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(64, 0, 1'b1, 1'b0, 1'b1, -1);
    finishRun("t2", 4'b0100);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t2_hold_bits", 32'({bit_a, bit_b, bit_c, bit_d}), 32'b0100);

    // N=128, half=64: 72 and 56 are exactly at the bounds, 73 and 55 just outside
    doStart(2'd1, "t3");
    applyStimulus(128, 72, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(128, 73, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(128, 55, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(128, 56, 1'b0, 1'b0, 1'b1, -1);
    finishRun("t3", 4'b0110);

    // 50% rng_valid duty, stray start and win_sel change during window 1
    doStart(2'd0, "t4");
    applyStimulus(64, 0, 1'b1, 1'b1, 1'b0, -1);
    applyStimulus(64, 41, 1'b0, 1'b1, 1'b0, 10);
    applyStimulus(64, 40, 1'b0, 1'b1, 1'b0, -1);
    applyStimulus(64, 23, 1'b0, 1'b1, 1'b0, -1);
    finishRun("t4", 4'b0101);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checkOutput("t4_single_done", 32'(done_seen), 32'd0);

    // Abort in the middle of window 2
    doStart(2'd0, "t5");
    applyStimulus(64, 64, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(64, 64, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("t5_pre_rst_bits", 32'({bit_a, bit_b}), 32'b11);
    applyStimulus(20, 20, 1'b0, 1'b0, 1'b0, -1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_bits", 32'({bit_a, bit_b, bit_c, bit_d}), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      rng_valid = 1'b1;
      rng_bit   = ~rng_bit;
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    rng_valid = 1'b0;
    checkOutput("t5_no_done", 32'(done_seen), 32'd0);
    doStart(2'd0, "t5b");
    applyStimulus(64, 0, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(64, 0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(64, 0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus(64, 0, 1'b1, 1'b0, 1'b1, -1);
    finishRun("t5b", 4'b1000);

`ifdef RNG_BIAS_DBG_CNT_EN
    // N=512 extremes on the debug counter
    doStart(2'd3, "t6z");
    for (int w = 0; w < 4; w++) applyStimulus(512, 0, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("t6_ones_zero", 32'(ones_cnt), 32'd0);
    finishRun("t6z", 4'b1111);
    doStart(2'd3, "t6o");
    for (int w = 0; w < 4; w++) applyStimulus(512, 512, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("t6_ones_full", 32'(ones_cnt), 32'd512);
    finishRun("t6o", 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
